fp_mul_round_stage: RTL and testbench
=====================================

FP_MUL_ROUND_STAGE -- requirements
Module: fp_mul_round_stage

Interface
REQ-001 Parameter EXP_BIAS, default 127: the IEEE-754 single-precision exponent bias subtracted from the raw exponent sum.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 in_valid  input  1  upstream multiplier has a product on the in_* buses.
REQ-005 in_ready  output  1  block accepts the in_* beat this cycle.
REQ-006 in_sign  input  1  result sign, sign1 XOR sign2.
REQ-007 in_exp_sum  input  9  raw biased exponent sum e1+e2, range 0..510.
REQ-008 in_frac  input  48  unsigned product of the two 24-bit significands {1,m1} and {1,m2}.
REQ-009 in_special  input  1  operand pair is a special case (zero/inf/NaN); bypass rounding.
REQ-010 in_special_val  input  32  pre-formed special-case result.
REQ-011 out_valid  output  1  out/out_flags hold a valid result.
REQ-012 out_ready  input  1  downstream consumes the result this cycle.
REQ-013 out  output  32  IEEE-754 single-precision result {sign, exp[7:0], mant[22:0]}.
REQ-014 out_flags  output  3  {overflow, underflow, inexact}.

Function
REQ-015 The block SHALL be a two-stage pipeline with S1 = normalise and S2 = round/pack; each stage SHALL have one valid bit, v1 and v2.
REQ-016 Transfers SHALL follow the handshake rules: in accepted when in_valid && in_ready; out consumed when out_valid && out_ready; out_valid = v2.
REQ-017 Advance rules: S2 loads when !v2 || out_ready; S1 loads when !v1 || S2 loads; in_ready = S1 load condition, which gives one result per cycle at full throughput.
REQ-018 Latency SHALL be exactly 2 cycles from acceptance to out_valid, with no stalls.
REQ-019 While out_valid && !out_ready, out and out_flags SHALL hold stable, and no beat SHALL be dropped or duplicated.
REQ-020 Normalisation in S1 when in_frac[47]=1: mant=in_frac[46:24], guard=in_frac[23], sticky=|in_frac[22:0], exp=in_exp_sum+1-EXP_BIAS.
REQ-021 Normalisation in S1 when in_frac[47]=0: mant=in_frac[45:23], guard=in_frac[22], sticky=|in_frac[21:0], exp=in_exp_sum-EXP_BIAS.
REQ-022 The S1 exponent SHALL be held as an 11-bit signed value, with no wrap-around.
REQ-023 Rounding in S2 SHALL be round-to-nearest-even: round_up = guard & (sticky | mant[0]); inexact = guard | sticky.
REQ-024 A rounding carry out of mant[22] SHALL give mant=0 and exp=exp+1.
REQ-025 Overflow: if the final exp >= 255, out = {sign, 8'hFF, 23'h0} and overflow=1, inexact=1.
REQ-026 Underflow: if the final exp <= 0, out = {sign, 31'h0} (flush to zero, no denormals) and underflow=1, inexact=1.
REQ-027 Special bypass: if in_special=1, out = in_special_val and out_flags=0, regardless of in_frac/in_exp_sum; the special bit SHALL be carried through both stages.
REQ-028 Otherwise out = {sign, exp[7:0], mant} with flags {0,0,inexact}.
REQ-029 in_ready SHALL depend on out_ready combinationally; no combinational path SHALL exist from in_valid to out_valid.

Reset
REQ-030 On rst_n=0, the block SHALL immediately clear v1 and v2 and drive out_valid=0, out=32'h0, out_flags=3'b000, in_ready=0.
REQ-031 After rst_n deasserts, in_ready SHALL be 1 from the first rising edge.
REQ-032 Beats in flight when reset asserts SHALL be discarded.

Verification
REQ-033 1.5x1.5: in_frac=48'h900000000000, exp_sum=254, sign=0 -> out=32'h40100000, flags=000, 2 cycles later.
REQ-034 Ties, exp_sum=254: in_frac=48'h400000C00000 -> 32'h3F800002, flags=001; in_frac=48'h400000400000 -> 32'h3F800000, flags=001.
REQ-035 Mantissa carry: in_frac=48'h7FFFFFC00000, exp_sum=254 -> 32'h40000000, inexact=1.
REQ-036 Overflow/underflow/special: exp_sum=400, frac=48'h400000000000 -> 32'h7F800000, flags=101; exp_sum=100, sign=1 -> 32'h80000000, flags=011; in_special=1, val=32'h7FC00000 -> 32'h7FC00000, flags=000.
REQ-037 Backpressure: stream 4 back-to-back beats with out_ready low for 3 cycles -> in_ready drops after 2 beats are held, out stays stable, all 4 results emerge in order with none lost or duplicated.
REQ-038 Reset mid-stream: assert rst_n=0 with v1=v2=1 -> out_valid=0 immediately, and no stale result appears after release.

Source files
------------

// File: rtl/fp_mul_round_stage.sv
// fp_mul_round_stage: normalise/round/pack back end of an IEEE-754
// single-precision multiplier. Two-stage valid/ready pipeline:
//   S1 normalises the 48-bit significand product and removes the exponent bias,
//   S2 rounds to nearest-even, detects overflow/underflow and packs the result.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid/ready  upstream handshake (in_ready is combinational on out_ready)
//   in_sign         result sign
//   in_exp_sum      raw biased exponent sum e1+e2 (0..510)
//   in_frac         48-bit product of the two 24-bit significands
//   in_special      bypass rounding and emit in_special_val instead
//   in_special_val  pre-formed special-case result
//   out_valid/ready downstream handshake
//   out             packed single-precision result
//   out_flags       {overflow, underflow, inexact}
module fp_mul_round_stage #(
  parameter int unsigned EXP_BIAS = 127
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [8:0]  in_exp_sum,
  input  logic [47:0] in_frac,
  input  logic        in_special,
  input  logic [31:0] in_special_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic [2:0]  out_flags
);

  localparam int unsigned EXP_W  = 11;
  localparam int unsigned MANT_W = 23;
  localparam int unsigned SIG_W  = MANT_W + 1;
  localparam int unsigned EXP_MAX = 255;

  // Pipeline control
  logic r_run;
  logic r_v1;
  logic r_v2;
  logic w_s1_load;
  logic w_s2_load;
  logic w_accept;

  // S1 state
  logic              r_sign1;
  logic [EXP_W-1:0]  r_exp1;
  logic [MANT_W-1:0] r_mant1;
  logic              r_guard1;
  logic              r_sticky1;
  logic              r_spec1;
  logic [31:0]       r_spec_val1;

  // S1 combinational normalisation
  logic              w_norm_hi;
  logic [MANT_W-1:0] w_mant1;
  logic              w_guard1;
  logic              w_sticky1;
  logic [EXP_W-1:0]  w_exp1;

  // S2 combinational round/pack
  logic              w_round_up;
  logic [SIG_W-1:0]  w_mant_sum;
  logic [EXP_W-1:0]  w_exp2;
  logic              w_ovf;
  logic              w_unf;
  logic              w_inexact;
  logic [31:0]       w_res;
  logic [2:0]        w_flags;

  // S2 state (drives the outputs)
  logic [31:0] r_out;
  logic [2:0]  r_flags;

  // Handshake: S2 frees when empty or drained, S1 frees when empty or moving on.
  // r_run keeps in_ready low while in reset and until the first clock edge.
  always_comb begin
    w_s2_load = !r_v2 || out_ready;
    w_s1_load = !r_v1 || w_s2_load;
    in_ready  = r_run && w_s1_load;
    w_accept  = in_valid && in_ready;
  end

  assign out_valid = r_v2;
  assign out       = r_out;
  assign out_flags = r_flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  // S1 normalisation: the product of two [1,2) significands lies in [1,4),
  // so bit 47 selects whether one extra position of shift is needed.
  always_comb begin
    w_norm_hi = in_frac[47];
    if (w_norm_hi) begin
      w_mant1   = in_frac[46:24];
      w_guard1  = in_frac[23];
      w_sticky1 = |in_frac[22:0];
    end else begin
      w_mant1   = in_frac[45:23];
      w_guard1  = in_frac[22];
      w_sticky1 = |in_frac[21:0];
    end
    // 11-bit two's-complement: range -127..384 never wraps
    w_exp1 = {2'b00, in_exp_sum} + EXP_W'(w_norm_hi) - EXP_W'(EXP_BIAS);
  end

  // S1 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1        <= 1'b0;
      r_sign1     <= 1'b0;
      r_exp1      <= '0;
      r_mant1     <= '0;
      r_guard1    <= 1'b0;
      r_sticky1   <= 1'b0;
      r_spec1     <= 1'b0;
      r_spec_val1 <= '0;
    end else begin
      if (in_ready) begin
        r_v1 <= in_valid;
      end
      if (w_accept) begin
        r_sign1     <= in_sign;
        r_exp1      <= w_exp1;
        r_mant1     <= w_mant1;
        r_guard1    <= w_guard1;
        r_sticky1   <= w_sticky1;
        r_spec1     <= in_special;
        r_spec_val1 <= in_special_val;
      end
    end
  end

  // S2 round-to-nearest-even and pack
  always_comb begin
    w_round_up = r_guard1 && (r_sticky1 || r_mant1[0]);
    w_inexact  = r_guard1 || r_sticky1;
    // A carry out of the mantissa leaves the low bits all zero
    w_mant_sum = {1'b0, r_mant1} + SIG_W'(w_round_up);
    w_exp2     = r_exp1 + EXP_W'(w_mant_sum[SIG_W-1]);
    w_ovf      = $signed(w_exp2) >= $signed(EXP_W'(EXP_MAX));
    w_unf      = $signed(w_exp2) <= $signed(EXP_W'(0));

    w_res   = {r_sign1, w_exp2[7:0], w_mant_sum[MANT_W-1:0]};
    w_flags = {2'b00, w_inexact};
    if (r_spec1) begin
      w_res   = r_spec_val1;
      w_flags = 3'b000;
    end else if (w_ovf) begin
      w_res   = {r_sign1, 8'hFF, 23'h0};
      w_flags = 3'b101;
    end else if (w_unf) begin
      w_res   = {r_sign1, 31'h0};
      w_flags = 3'b011;
    end
  end

  // S2 register: holds while stalled so out/out_flags stay stable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2    <= 1'b0;
      r_out   <= '0;
      r_flags <= '0;
    end else if (w_s2_load) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_out   <= w_res;
        r_flags <= w_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_round_stage.sv
// Directed bench for fp_mul_round_stage: hand-computed vectors, an in-order
// expected-result queue filled on acceptance and drained on consumption.
module tb_fp_mul_round_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [8:0]  in_exp_sum;
  logic [47:0] in_frac;
  logic        in_special;
  logic [31:0] in_special_val;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic [2:0]  out_flags;

  int n_chk = 0;
  int n_err = 0;

  logic [34:0] q[$];
  logic [34:0] pend;
  logic [34:0] snap;
  logic        acc;

  fp_mul_round_stage #(.EXP_BIAS(127)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_sign        (in_sign),
    .in_exp_sum     (in_exp_sum),
    .in_frac        (in_frac),
    .in_special     (in_special),
    .in_special_val (in_special_val),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out            (out),
    .out_flags      (out_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes just before the edge, end on the negedge.
  task automatic tick();
    #1;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_chk++;
        n_err++;
        $error("FAIL spurious_out observed=%h expected=none", {out_flags, out});
      end else begin
        chk("out_order", {29'h0, out_flags, out}, {29'h0, q.pop_front()});
      end
    end
    if (acc) q.push_back(pend);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic s, input logic [8:0] e, input logic [47:0] f,
                       input logic sp, input logic [31:0] sv,
                       input logic [31:0] xo, input logic [2:0] xf);
    in_valid       = 1'b1;
    in_sign        = s;
    in_exp_sum     = e;
    in_frac        = f;
    in_special     = sp;
    in_special_val = sv;
    pend           = {xf, xo};
  endtask

  task automatic wait_accept(input string tag);
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) tick();
    if (!acc) begin
      n_chk++;
      n_err++;
      $error("FAIL %s_timeout observed=not_accepted expected=accepted", tag);
    end
    in_valid = 1'b0;
  endtask

  task automatic send(input string tag, input logic s, input logic [8:0] e,
                      input logic [47:0] f, input logic sp, input logic [31:0] sv,
                      input logic [31:0] xo, input logic [2:0] xf);
    drive(s, e, f, sp, sv, xo, xf);
    wait_accept(tag);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    in_valid = 1'b0; in_sign = 1'b0; in_exp_sum = '0; in_frac = '0;
    in_special = 1'b0; in_special_val = '0; out_ready = 1'b1; pend = '0;

    // Reset state
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out", {29'h0, out_flags, out}, 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("ready_after_release", 64'(in_ready), 64'd1);

    // 1.5 x 1.5 with latency check
    drive(1'b0, 9'd254, 48'h900000000000, 1'b0, 32'h0, 32'h40100000, 3'b000);
    tick();
    in_valid = 1'b0;
    chk("lat_cycle1_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    tick();
    chk("lat_cycle2_valid", 64'(out_valid), 64'd1);
    chk("lat_cycle2_out", {29'h0, out_flags, out}, {29'h0, 3'b000, 32'h40100000});
    out_ready = 1'b1;
    drain();

    // Back-to-back directed vectors at full throughput
    send("tie_up",   1'b0, 9'd254, 48'h400000C00000, 1'b0, 32'h0, 32'h3F800002, 3'b001);
    send("tie_even", 1'b0, 9'd254, 48'h400000400000, 1'b0, 32'h0, 32'h3F800000, 3'b001);
    send("carry",    1'b0, 9'd254, 48'h7FFFFFC00000, 1'b0, 32'h0, 32'h40000000, 3'b001);
    send("ovf",      1'b0, 9'd400, 48'h400000000000, 1'b0, 32'h0, 32'h7F800000, 3'b101);
    send("unf",      1'b1, 9'd100, 48'h400000000000, 1'b0, 32'h0, 32'h80000000, 3'b011);
    send("special",  1'b0, 9'd300, 48'hC00000000001, 1'b1, 32'h7FC00000, 32'h7FC00000, 3'b000);
    send("neg_exact", 1'b1, 9'd200, 48'h400000000000, 1'b0, 32'h0, 32'hA4800000, 3'b000);
    drain();

    // Backpressure: out_ready low for 3 cycles while streaming 4 beats
    out_ready = 1'b0;
    send("bp_a", 1'b0, 9'd254, 48'h900000000000, 1'b0, 32'h0, 32'h40100000, 3'b000);
    send("bp_b", 1'b0, 9'd254, 48'h400000C00000, 1'b0, 32'h0, 32'h3F800002, 3'b001);
    chk("bp_valid", 64'(out_valid), 64'd1);
    snap = {out_flags, out};
    chk("bp_head", {29'h0, snap}, {29'h0, 3'b000, 32'h40100000});
    drive(1'b0, 9'd254, 48'h7FFFFFC00000, 1'b0, 32'h0, 32'h40000000, 3'b001);
    #1;
    chk("bp_ready_low", 64'(in_ready), 64'd0);
    tick();
    chk("bp_ready_still_low", 64'(in_ready), 64'd0);
    chk("bp_hold", {29'h0, out_flags, out}, {29'h0, snap});
    out_ready = 1'b1;
    wait_accept("bp_c");
    send("bp_d", 1'b0, 9'd10, 48'h0, 1'b1, 32'hFF800000, 32'hFF800000, 3'b000);
    drain();

    // Reset with both stages full
    out_ready = 1'b0;
    send("mid_a", 1'b0, 9'd254, 48'h900000000000, 1'b0, 32'h0, 32'h40100000, 3'b000);
    send("mid_b", 1'b0, 9'd400, 48'h400000000000, 1'b0, 32'h0, 32'h7F800000, 3'b101);
    chk("mid_full_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_out", {29'h0, out_flags, out}, 64'h0);
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("mid_no_stale", 64'(out_valid), 64'd0);
    chk("mid_ready", 64'(in_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
